// File: rtl/seq_detect_sched_pkg.sv
// Shared types for the shared-1011-detector scheduler: detector and controller state encodings.
package seq_detect_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S1,
        S10,
        S101,
        S1011
    } det_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_LOAD,
        C_SHIFT,
        C_REPORT
    } ctl_state_t;

endpackage

// File: rtl/seq_detect_sched_if.sv
// Requester-side bus of the scheduler. With SEQ_DETECT_SCHED_FIRST_HIT_EN the first-hit report is added.
interface seq_detect_sched_if #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 16
);
    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int ID_W  = $clog2(NREQ);
    localparam int POS_W = $clog2(WORD_W);

    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] data;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [CNT_W-1:0]       match_cnt;
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
    logic                   first_vld;
    logic [POS_W-1:0]       first_pos;
`endif

    modport master (
        output req, data,
        input  gnt, busy, done, done_id, match_cnt
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
        , input first_vld, first_pos
`endif
    );

    modport slave (
        input  req, data,
        output gnt, busy, done, done_id, match_cnt
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
        , output first_vld, first_pos
`endif
    );

endinterface

// File: rtl/seq_detect_1011_core.sv
// Serial 1011 detector with overlap; hit is a Mealy output in the cycle the final 1 arrives.
module seq_detect_1011_core
    import seq_detect_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic bit_in,
    output logic hit
);

    det_state_t r_state;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (clr) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    r_state <= bit_in ? S1    : IDLE;
                S1:      r_state <= bit_in ? S1    : S10;
                S10:     r_state <= bit_in ? S101  : IDLE;
                S101:    r_state <= bit_in ? S1011 : S10;
                S1011:   r_state <= bit_in ? S1    : S10;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hit = (r_state == S101) && bit_in;

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one 1011 detector among NREQ requesters.
// Optional first-hit report enabled by defining SEQ_DETECT_SCHED_FIRST_HIT_EN.
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    seq_detect_sched_if.slave bus
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int ID_W  = $clog2(NREQ);
    localparam int BC_W  = $clog2(WORD_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

    ctl_state_t        r_state;
    logic [ID_W-1:0]   r_last_id;
    logic [ID_W-1:0]   r_sel_id;
    logic [WORD_W-1:0] r_shift;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [NREQ-1:0]   r_gnt;
    logic              r_busy;
    logic              r_done;
    logic [ID_W-1:0]   r_done_id;
    logic [CNT_W-1:0]  r_match_cnt;
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
    logic              r_fh_vld;
    logic [BC_W-1:0]   r_fh_pos;
    logic              r_first_vld;
    logic [BC_W-1:0]   r_first_pos;
`endif

    logic              w_pick_vld;
    logic [ID_W-1:0]   w_pick_id;
    logic              w_hit;
    logic [WORD_W-1:0] w_word;

    // Scan from the farthest candidate to the nearest so the nearest set bit after last_id wins.
    always_comb begin
        // NOTE: defaults first so no path leaves a comb output unassigned (no latch).
        w_pick_vld = 1'b0;
        w_pick_id  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (bus.req[(int'(r_last_id) + i) % NREQ]) begin
                w_pick_vld = 1'b1;
                w_pick_id  = ID_W'((int'(r_last_id) + i) % NREQ);
            end
        end
    end

    assign w_word = bus.data[int'(r_sel_id)*WORD_W +: WORD_W];

    seq_detect_1011_core u_core (
        .clk    (clk),
        .reset  (reset),
        .clr    (r_state == C_LOAD),
        .bit_in (r_shift[WORD_W-1]),
        .hit    (w_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= C_IDLE;
            r_last_id   <= ID_W'(NREQ - 1);
            r_sel_id    <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= '0;
            r_match_cnt <= '0;
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
            r_fh_vld    <= 1'b0;
            r_fh_pos    <= '0;
            r_first_vld <= 1'b0;
            r_first_pos <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (w_pick_vld) begin
                        r_sel_id <= w_pick_id;
                        r_gnt    <= NREQ'(1) << w_pick_id;
                        r_busy   <= 1'b1;
                        r_state  <= C_LOAD;
                    end
                end
                C_LOAD: begin
                    r_shift   <= w_word;
                    r_bit_cnt <= '0;
                    r_cnt     <= '0;
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
                    r_fh_vld  <= 1'b0;
                    r_fh_pos  <= '0;
`endif
                    r_state   <= C_SHIFT;
                end
                C_SHIFT: begin
                    r_shift   <= r_shift << 1;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    r_cnt     <= r_cnt + CNT_W'(w_hit);
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
                    if (w_hit && !r_fh_vld) begin
                        r_fh_vld <= 1'b1;
                        r_fh_pos <= r_bit_cnt;
                    end
`endif
                    // Final bit's hit is folded straight into the reported values.
                    if (r_bit_cnt == LAST_BIT) begin
                        r_done      <= 1'b1;
                        r_done_id   <= r_sel_id;
                        r_match_cnt <= r_cnt + CNT_W'(w_hit);
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
                        r_first_vld <= r_fh_vld | w_hit;
                        r_first_pos <= r_fh_vld ? r_fh_pos : (w_hit ? r_bit_cnt : '0);
`endif
                        r_state     <= C_REPORT;
                    end
                end
                C_REPORT: begin
                    r_last_id <= r_sel_id;
                    r_gnt     <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= C_IDLE;
                end
                default: r_state <= C_IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.done_id   = r_done_id;
    assign bus.match_cnt = r_match_cnt;
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
    assign bus.first_vld = r_first_vld;
    assign bus.first_pos = r_first_pos;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: directed and random jobs checked against a pattern-search and round-robin model.
module tb_seq_detect_sched;

    localparam int NREQ   = 4;
    localparam int WORD_W = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_last   = NREQ - 1;

    always #5 clk = ~clk;

    seq_detect_sched_if #(.NREQ(NREQ), .WORD_W(WORD_W)) bus ();

    seq_detect_sched #(.NREQ(NREQ), .WORD_W(WORD_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit k of a job is the k-th bit shifted out, i.e. word[WORD_W-1-k].
    function automatic logic word_bit(input logic [WORD_W-1:0] w, input int k);
        return w[WORD_W-1-k];
    endfunction

    function automatic bit window_match(input logic [WORD_W-1:0] w, input int p);
        return word_bit(w, p-3) == 1'b1 && word_bit(w, p-2) == 1'b0 &&
               word_bit(w, p-1) == 1'b1 && word_bit(w, p)   == 1'b1;
    endfunction

    function automatic int ref_count(input logic [WORD_W-1:0] w);
        int n = 0;
        for (int p = 3; p < WORD_W; p++) if (window_match(w, p)) n++;
        return n;
    endfunction

    function automatic int ref_first(input logic [WORD_W-1:0] w);
        for (int p = 3; p < WORD_W; p++) if (window_match(w, p)) return p;
        return -1;
    endfunction

    function automatic int ref_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input int id, input logic [WORD_W-1:0] w);
        bus.data[id*WORD_W +: WORD_W] = w;
        bus.req[id] = 1'b1;
    endtask

    // Waits for done (bounded), checking latency, grant and result against the model.
    task automatic serve(input int lat, input string tag);
        int exp_id;
        int cyc;
        logic [WORD_W-1:0] w;
        exp_id = ref_pick(bus.req, m_last);
        if (exp_id < 0) exp_id = 0;
        w   = bus.data[exp_id*WORD_W +: WORD_W];
        cyc = 0;
        do begin
            step();
            cyc++;
            if (cyc == lat - WORD_W - 1) begin
                check({tag, ".gnt_load"}, 32'(bus.gnt), 32'(1) << exp_id);
                check({tag, ".busy"}, 32'(bus.busy), 32'd1);
            end
        end while (!bus.done && cyc < 40);
        check({tag, ".latency"}, 32'(cyc), 32'(lat));
        check({tag, ".done_id"}, 32'(bus.done_id), 32'(exp_id));
        check({tag, ".match_cnt"}, 32'(bus.match_cnt), 32'(ref_count(w)));
        check({tag, ".gnt_done"}, 32'(bus.gnt), 32'(1) << exp_id);
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
        check({tag, ".first_vld"}, 32'(bus.first_vld), (ref_first(w) >= 0) ? 32'd1 : 32'd0);
        check({tag, ".first_pos"}, 32'(bus.first_pos), (ref_first(w) >= 0) ? 32'(ref_first(w)) : 32'd0);
`endif
        m_last = exp_id;
        bus.req[exp_id] = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] mask;
        reset    = 1'b1;
        bus.req  = '0;
        bus.data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.gnt", 32'(bus.gnt), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.done_id", 32'(bus.done_id), 32'd0);
        check("rst.match_cnt", 32'(bus.match_cnt), 32'd0);
        reset = 1'b0;

        // Single jobs from requester 0: basic match, overlap, and no-match words.
        set_job(0, 16'hB000);
        serve(18, "first");
        step();
        set_job(0, 16'hB6DB);
        serve(18, "overlap");
        step();
        set_job(0, 16'hFFFF);
        serve(18, "ones");
        step();
        set_job(0, 16'h0000);
        serve(18, "zeros");

        // Park the pointer on 3, then all four requesters: 0,1,2,3 back to back, then 0 again.
        step();
        set_job(3, WORD_W'($urandom));
        serve(18, "pre3");
        step();
        for (int i = 0; i < NREQ; i++) set_job(i, WORD_W'($urandom));
        serve(18, "rr0");
        serve(19, "rr1");
        serve(19, "rr2");
        serve(19, "rr3");
        step();
        set_job(0, WORD_W'($urandom));
        serve(18, "rr0b");

        // Random request masks and words; losers withdraw after each job.
        for (int n = 0; n < 8; n++) begin
            step();
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) if (mask[i]) set_job(i, WORD_W'($urandom));
            serve(18, "rand");
            bus.req = '0;
        end

        // Pointer on 1, then req=1010: requester 3 goes first, then 1.
        step();
        set_job(1, WORD_W'($urandom));
        serve(18, "pre1");
        step();
        set_job(1, WORD_W'($urandom));
        set_job(3, WORD_W'($urandom));
        serve(18, "alt3");
        serve(19, "alt1");

        // Reset in the middle of a job for requester 2; afterwards requester 0 regains priority.
        step();
        set_job(0, WORD_W'($urandom));
        set_job(2, WORD_W'($urandom));
        repeat (6) step();
        check("mid.gnt", 32'(bus.gnt), 32'b0100);
        #1 reset = 1'b1;
        #1;
        check("mid_rst.gnt", 32'(bus.gnt), 32'd0);
        check("mid_rst.busy", 32'(bus.busy), 32'd0);
        check("mid_rst.done", 32'(bus.done), 32'd0);
        step();
        check("mid_rst.done_held", 32'(bus.done), 32'd0);
        reset  = 1'b0;
        m_last = NREQ - 1;
        serve(18, "post_rst");
        step();
        check("post_rst.gnt_idle", 32'(bus.gnt), 32'd0);
        check("post_rst.done_pulse", 32'(bus.done), 32'd0);
        bus.req = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
